// File: rtl/iterative_divider.sv
// ----------------------------------------------------------------------------
// iterative_divider
//   Multi-cycle integer divide unit for RV32M DIV/DIVU/REM/REMU.
//   Uses restoring shift-subtract with one quotient bit per clock. Operand
//   magnitudes are divided unsigned. Signs are applied in a single fix-up
//   cycle. Divide-by-zero and signed overflow skip the iteration and are
//   resolved directly in that fix-up cycle.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : request, sampled only while busy=0
//   op        : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  : rs1 value, latched on accept
//   divisor   : rs2 value, latched on accept
//   busy      : high from the accept edge through the done cycle
//   done      : one-cycle pulse, result valid
//   result    : quotient or remainder, held until overwritten
// ----------------------------------------------------------------------------
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next;

  // Two's complement negation, mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    f_neg = ~x + WIDTH'(1);
  endfunction

  // Magnitude of an operand; neg says whether it is a negative signed value.
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x,
                                             input logic             neg);
    f_abs = neg ? f_neg(x) : x;
  endfunction

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_div0;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  logic signed [WIDTH-1:0] w_dvd_s;
  logic signed [WIDTH-1:0] w_dvs_s;
  logic                    w_accept;
  logic                    w_signed;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic                    w_div0;
  logic                    w_ovf;
  logic [WIDTH:0]          w_rs;
  logic [WIDTH+1:0]        w_trial;
  logic                    w_fits;
  logic [WIDTH-1:0]        w_fix_val;

  assign w_dvd_s  = dividend;
  assign w_dvs_s  = divisor;
  assign w_accept = (r_state == S_IDLE) && start;
  // op[0]=0 selects the signed variants (DIV, REM).
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed && (w_dvd_s < 0);
  assign w_b_neg  = w_signed && (w_dvs_s < 0);
  assign w_div0   = (divisor == '0);
  assign w_ovf    = w_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (divisor == '1);

  // Shifted partial remainder needs one extra bit; the trial keeps another
  // so its MSB is a clean borrow flag.
  assign w_rs    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = {1'b0, w_rs} - {2'b00, r_dvs};
  assign w_fits  = ~w_trial[WIDTH+1];

  always_comb begin
    w_fix_val = '0;
    if (r_div0) begin
      w_fix_val = r_op[1] ? r_dvd_raw : '1;
    end else if (r_ovf) begin
      w_fix_val = r_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      case (r_op)
        2'b00:   w_fix_val = r_qneg ? f_neg(r_quo) : r_quo;
        2'b01:   w_fix_val = r_quo;
        2'b10:   w_fix_val = r_rneg ? f_neg(r_rem) : r_rem;
        default: w_fix_val = r_rem;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_div0 || w_ovf) ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == LAST_CNT) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_dvd_raw <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= op;
            r_quo     <= f_abs(dividend, w_a_neg);
            r_rem     <= '0;
            r_dvs     <= f_abs(divisor, w_b_neg);
            r_dvd_raw <= dividend;
            r_qneg    <= w_a_neg ^ w_b_neg;
            r_rneg    <= w_a_neg;
            r_div0    <= w_div0;
            r_ovf     <= w_ovf;
            r_cnt     <= '0;
          end
        end
        S_CALC: begin
          r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_rs[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX:   r_result <= w_fix_val;
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  localparam int W = 32;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  iterative_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Wait (bounded) for done; k counts edges after the accept edge.
  task automatic wait_done(inout int k);
    while (done !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Issue one op from an IDLE cycle, check busy, latency, result, and that
  // done lasts one cycle. Returns one edge after done, i.e. in IDLE.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat);
    int k;
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    chk({name, " busy"}, W'(busy), W'(1));
    k = 0;
    wait_done(k);
    chk({name, " latency"}, W'(k + 1), W'(lat));
    chk({name, " result"}, result, exp);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, W'({busy, done}), W'(0));
    chk({name, " held"}, result, exp);
  endtask

  initial begin
    int k;
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34};
    vecs[3]  = '{REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34};
    vecs[4]  = '{REM,  32'd7,          32'hFFFFFFFE,   32'd1,          34};
    vecs[5]  = '{DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34};
    vecs[6]  = '{DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   2};
    vecs[7]  = '{REMU, 32'h12345678,   32'd0,          32'h12345678,   2};
    vecs[8]  = '{REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   2};
    vecs[9]  = '{DIVU, 32'd9,          32'd0,          32'hFFFFFFFF,   2};
    vecs[10] = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   2};
    vecs[11] = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          2};
    vecs[12] = '{DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         34};
    vecs[13] = '{REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   34};
    vecs[14] = '{DIVU, 32'h80000000,   32'd3,          32'h2AAAAAAA,   34};
    vecs[15] = '{REMU, 32'h80000000,   32'd3,          32'd2,          34};
    vecs[16] = '{DIV,  32'h80000000,   32'd1,          32'h80000000,   34};
    vecs[17] = '{DIV,  32'd0,          32'd5,          32'd0,          34};
    vecs[18] = '{DIVU, 32'd5,          32'hFFFFFFFF,   32'd0,          34};
    vecs[19] = '{REMU, 32'd5,          32'hFFFFFFFF,   32'd5,          34};

    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   W'(busy), W'(0));
    chk("reset done",   W'(done), W'(0));
    chk("reset result", result,   W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Every vector starts in the first IDLE cycle after the previous done.
    for (int i = 0; i < 20; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);

    // start with new operands mid-operation must be ignored.
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    repeat (10) begin @(posedge clk); #1; k++; end
    op = DIV; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    k++;
    start = 1'b0; dividend = 32'hDEADBEEF; divisor = 32'd1;
    wait_done(k);
    chk("busy_ignore latency", W'(k + 1), W'(34));
    chk("busy_ignore result",  result, W'(14));

    // start in the DONE cycle must be ignored.
    op = DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_cycle_ignored busy", W'(busy), W'(0));
    chk("done_cycle_ignored result", result, W'(14));
    run_op("after_done", DIVU, 32'd50, 32'd5, 32'd10, 34);

    // Asynchronous reset in the middle of CALC.
    op = DIVU; dividend = 32'hFFFFFFFF; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst busy",   W'(busy), W'(0));
    chk("async_rst done",   W'(done), W'(0));
    chk("async_rst result", result,   W'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
